// File: rtl/clk_div_monitor.sv
// clk_div_monitor: built-in self-check for a divided clock generated in the
// clk100 domain. The divided clock is sampled as data, its period is measured
// in clk100 cycles, lock is declared after LOCK_CNT consecutive good periods,
// and a sticky fault is raised on a bad period or a stopped clock.
// Optional high-time (duty) check: define CLK_MON_DUTY_CHECK_EN.
module clk_div_monitor #(
  parameter int DIV      = 4,   // expected period in clk100 cycles (2..255)
  parameter int TOL      = 0,   // allowed period error, +/- cycles
  parameter int LOCK_CNT = 4,   // consecutive good periods for lock (1..15)
  parameter int TIMEOUT  = 64   // cycles without a rise that mean "stopped"
) (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       div_clk_in,
  input  logic       clr,
  output logic       locked,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] period
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;

  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_PERIOD = 2'b01;
  localparam logic [1:0] CODE_STOP   = 2'b10;
  localparam logic [1:0] CODE_DUTY   = 2'b11;

  localparam int         GOOD_LO     = DIV - TOL;
  localparam int         GOOD_HI     = DIV + TOL;
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);
  localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);

  // s1 = sync_reg[0], s2 = sync_reg[1], s3 = sync_reg[2]
  logic [2:0] sync_reg;
  logic       rise;
  logic [7:0] cnt_reg;
  logic       good_period;
  logic       timeout;
  logic       duty_bad;

  state_t     state_reg, state_next;
  logic [3:0] good_cnt_reg, good_cnt_next;
  logic [1:0] code_reg, code_next;
  logic       locked_reg, locked_next;
  logic       fault_reg, fault_next;
  logic [7:0] period_reg;

  // Three-flop chain: two for metastability, the third for edge detection.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) sync_reg <= 3'b000;
    else        sync_reg <= {sync_reg[1:0], div_clk_in};
  end

  assign rise = sync_reg[1] & ~sync_reg[2];

  // Period counter: restarts at 1 on every rise, otherwise counts up and sticks at 255.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n)                cnt_reg <= 8'd0;
    else if (clr)              cnt_reg <= 8'd0;
    else if (rise)             cnt_reg <= 8'd1;
    else if (cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
  end

  // The counter value seen on the rise cycle is the length of the period just ended.
  assign good_period = (int'(cnt_reg) >= GOOD_LO) && (int'(cnt_reg) <= GOOD_HI);

  // A rise in the same cycle always wins over the timeout.
  assign timeout = (cnt_reg == TIMEOUT_VAL) && !rise;

`ifdef CLK_MON_DUTY_CHECK_EN
  localparam int DUTY_LO = DIV / 2 - TOL;
  localparam int DUTY_HI = DIV / 2 + TOL;

  logic       fall;
  logic [7:0] hi_cnt_reg;

  assign fall = ~sync_reg[1] & sync_reg[2];

  // High-time counter: starts at 1 on a rise and counts while the sampled clock stays high.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n)                                  hi_cnt_reg <= 8'd0;
    else if (clr)                                hi_cnt_reg <= 8'd0;
    else if (rise)                               hi_cnt_reg <= 8'd1;
    else if (sync_reg[1] && hi_cnt_reg != 8'hFF) hi_cnt_reg <= hi_cnt_reg + 8'd1;
  end

  // The count is complete on the fall cycle, so it is judged right there.
  assign duty_bad = fall && ((int'(hi_cnt_reg) < DUTY_LO) || (int'(hi_cnt_reg) > DUTY_HI));
`else
  assign duty_bad = 1'b0;
`endif

  // State register plus the registered status outputs.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      good_cnt_reg <= 4'd0;
      code_reg     <= CODE_NONE;
      locked_reg   <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
      code_reg     <= code_next;
      locked_reg   <= locked_next;
      fault_reg    <= fault_next;
    end
  end

  // Next-state logic: clr overrides everything, then per-state rise/timeout handling.
  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    code_next     = code_reg;
    if (clr) begin
      state_next    = IDLE;
      good_cnt_next = 4'd0;
      code_next     = CODE_NONE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rise) begin
            state_next    = ACQ;
            good_cnt_next = 4'd0;
          end
        end
        ACQ: begin
          if (rise) begin
            if (good_period) begin
              if (good_cnt_reg == LOCK_LAST) begin
                state_next    = LOCKED;
                good_cnt_next = 4'd0;
              end else begin
                good_cnt_next = good_cnt_reg + 4'd1;
              end
            end else begin
              good_cnt_next = 4'd0;
            end
          end else if (timeout) begin
            state_next    = IDLE;
            good_cnt_next = 4'd0;
          end
        end
        LOCKED: begin
          if (rise && !good_period) begin
            state_next = FAULT;
            code_next  = CODE_PERIOD;
          end else if (timeout) begin
            state_next = FAULT;
            code_next  = CODE_STOP;
          end else if (duty_bad) begin
            state_next = FAULT;
            code_next  = CODE_DUTY;
          end
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next    = IDLE;
          good_cnt_next = 4'd0;
          code_next     = CODE_NONE;
        end
      endcase
    end
  end

  // Output decode from the next state so the flags come straight from flops.
  always_comb begin
    locked_next = (state_next == LOCKED);
    fault_next  = (state_next == FAULT);
  end

  // Last measured period: updated on every rise except the one that leaves IDLE; clr keeps it.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n)                                 period_reg <= 8'd0;
    else if (!clr && rise && state_reg != IDLE) period_reg <= cnt_reg;
  end

  assign locked     = locked_reg;
  assign fault      = fault_reg;
  assign fault_code = code_reg;
  assign period     = period_reg;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed bench for clk_div_monitor (DIV=4, TOL=0,
// LOCK_CNT=4, TIMEOUT=64). Expected {locked, fault, fault_code, period}
// values are queued with a due cycle when the stimulus is driven and compared
// when that cycle arrives. Duty expectations follow CLK_MON_DUTY_CHECK_EN.
module tb_clk_div_monitor;

  logic       clk100 = 1'b0;
  logic       rst_n;
  logic       div_clk_in;
  logic       clr;
  logic       locked;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] period;
  logic [11:0] obs;
  logic [11:0] e_duty;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    string       tag;
    int          due;
    logic [11:0] exp;
  } sb_t;

  typedef struct {
    string       tag;
    int          on_clr;
    int          lat;
    logic [11:0] exp;
  } plan_t;

  sb_t   sb[$];
  plan_t plans[$];

  clk_div_monitor #(
    .DIV(4), .TOL(0), .LOCK_CNT(4), .TIMEOUT(64)
  ) dut (
    .clk100     (clk100),
    .rst_n      (rst_n),
    .div_clk_in (div_clk_in),
    .clr        (clr),
    .locked     (locked),
    .fault      (fault),
    .fault_code (fault_code),
    .period     (period)
  );

  always #5 clk100 = ~clk100;

  always @(posedge clk100) cyc <= cyc + 1;

  assign obs = {locked, fault, fault_code, period};

  // Packs an expected {locked, fault, code, period} word.
  function automatic logic [11:0] st(input int l, input int f, input int c, input int p);
    return {l[0], f[0], c[1:0], p[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h ({locked,fault,code,period})", tag, got, want);
    end
  endtask

  // Queue an expectation, anchored to the rise tick (on_clr=0) or clr tick (on_clr=1) of the next drive.
  task automatic plan(input string tag, input int on_clr, input int lat, input logic [11:0] e);
    plan_t p;
    p.tag    = tag;
    p.on_clr = on_clr;
    p.lat    = lat;
    p.exp    = e;
    plans.push_back(p);
  endtask

  task automatic arm(input int on_clr);
    sb_t s;
    foreach (plans[i]) begin
      if (plans[i].on_clr == on_clr) begin
        s.tag = plans[i].tag;
        s.due = cyc + plans[i].lat;
        s.exp = plans[i].exp;
        sb.push_back(s);
      end
    end
  endtask

  // One waveform period: 'low' cycles of 0 then 'high' cycles of 1; clr pulsed at index clr_idx.
  task automatic drive(input int low, input int high, input int clr_idx);
    for (int i = 0; i < low + high; i++) begin
      @(negedge clk100);
      div_clk_in = (i >= low);
      clr        = (i == clr_idx);
      if (i == low)     arm(0);
      if (i == clr_idx) arm(1);
    end
    plans.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk100);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: compare every entry whose due cycle has arrived.
  always @(negedge clk100) begin : mon
    int k;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].due == cyc) begin
        check(sb[k].tag, 32'(obs), 32'(sb[k].exp));
        sb.delete(k);
      end else begin
        k++;
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    div_clk_in = 1'b0;
    clr        = 1'b0;
`ifdef CLK_MON_DUTY_CHECK_EN
    e_duty = st(0, 1, 3, 4);
`else
    e_duty = st(1, 0, 0, 4);
`endif
    repeat (3) @(posedge clk100);
    #1 check("reset_state", 32'(obs), 32'd0);
    @(negedge clk100);
    rst_n = 1'b1;

    // Lock on an ideal 0,0,1,1 clock
    plan("t1_rise1_no_period", 0, 3, st(0, 0, 0, 0));
    drive(2, 2, -1);
    repeat (3) begin
      plan("t1_acquiring", 0, 3, st(0, 0, 0, 4));
      drive(2, 2, -1);
    end
    plan("t1_locked_rise5", 0, 3, st(1, 0, 0, 4));
    drive(2, 2, -1);
    plan("t1_stays_locked", 0, 3, st(1, 0, 0, 4));
    drive(2, 2, -1);

    // Stretched period of 6 cycles
    plan("t2_locked_before_bad", 0, 2, st(1, 0, 0, 4));
    plan("t2_bad_period", 0, 3, st(0, 1, 1, 6));
    drive(4, 2, -1);
    repeat (2) begin
      plan("t2_fault_sticky", 0, 3, st(0, 1, 1, 4));
      drive(2, 2, -1);
    end

    // clr between rises, then relock after 5 rises
    plan("t4_clr_clears", 1, 1, st(0, 0, 0, 4));
    plan("t4_first_rise_after_clr", 0, 3, st(0, 0, 0, 4));
    drive(2, 2, 1);
    repeat (3) begin
      plan("t4_reacquire", 0, 3, st(0, 0, 0, 4));
      drive(2, 2, -1);
    end
    plan("t4_relocked_5th_rise", 0, 3, st(1, 0, 0, 4));
    drive(2, 2, -1);
    drive(2, 2, -1);

    // clr on the same cycle as a detected rise
    plan("t4_clr_beats_rise", 1, 1, st(0, 0, 0, 4));
    plan("t4_rise1_after_clr_rise", 0, 3, st(0, 0, 0, 4));
    drive(2, 2, 0);
    repeat (3) begin
      plan("t4_reacquire2", 0, 3, st(0, 0, 0, 4));
      drive(2, 2, -1);
    end
    plan("t4_relocked_again", 0, 3, st(1, 0, 0, 4));
    drive(2, 2, -1);

    // Stopped clock: fault exactly 64 cycles after the last detected rise
    plan("t3_last_rise", 0, 3, st(1, 0, 0, 4));
    plan("t3_63_cycles_still_locked", 0, 66, st(1, 0, 0, 4));
    plan("t3_stop_at_64", 0, 67, st(0, 1, 2, 4));
    drive(2, 2, -1);
    drive(300, 0, -1);
    plan("t3_saturated_period", 0, 3, st(0, 1, 2, 255));
    drive(2, 2, -1);
    plan("t3_period_tracks_in_fault", 0, 3, st(0, 1, 2, 4));
    drive(2, 2, -1);

    // Clear and relock before the reset test
    plan("t5_pre_clr", 1, 1, st(0, 0, 0, 4));
    drive(2, 2, 1);
    repeat (3) drive(2, 2, -1);
    plan("t5_pre_locked", 0, 3, st(1, 0, 0, 4));
    drive(2, 2, -1);
    drain();

    // Asynchronous reset while locked
    @(posedge clk100);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset", 32'(obs), 32'd0);
    div_clk_in = 1'b0;
    repeat (2) @(negedge clk100);
    rst_n = 1'b1;
    plan("t5_first_rise_no_period", 0, 3, st(0, 0, 0, 0));
    drive(2, 2, -1);
    plan("t5_second_rise_period", 0, 3, st(0, 0, 0, 4));
    drive(2, 2, -1);
    repeat (2) drive(2, 2, -1);
    plan("t5_relocked", 0, 3, st(1, 0, 0, 4));
    drive(2, 2, -1);

    // Switch to a 1-of-4 high time, keeping the rise spacing at 4
    plan("t6_rise_short_high", 0, 3, st(1, 0, 0, 4));
    plan("t6_at_short_fall", 0, 4, e_duty);
    drive(2, 1, -1);
    repeat (2) begin
      plan("t6_after_fall", 0, 3, e_duty);
      drive(3, 1, -1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
